// File: rtl/wide_zero_counter_pkg.sv
// Shared types and helpers for the multi-cycle wide zero counter.
// Holds the FSM state type, scan-mode encodings and the count-width helper.
package wide_zero_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_TRAILING = 1'b0;
    localparam logic MODE_LEADING  = 1'b1;

    // Bits needed to hold a zero count in 0..w inclusive.
    function automatic int count_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/wide_zero_counter_slice_zero_count.sv
// Combinational zero counter for one slice, trailing or leading per mode.
// Ports: slice/mode in; count (0..SLICE_WIDTH) and all_zero out.
module slice_zero_count
    import wide_zero_counter_pkg::*;
#(
    parameter int SLICE_WIDTH = 8
) (
    input  logic [SLICE_WIDTH-1:0]                   slice,
    input  logic                                     mode,
    output logic [count_width(SLICE_WIDTH)-1:0]      count,
    output logic                                     all_zero
);

    localparam int SCW = count_width(SLICE_WIDTH);

    logic hit;
    logic bitv;

    always_comb begin
        count = '0;
        hit   = 1'b0;
        bitv  = 1'b0;
        for (int i = 0; i < SLICE_WIDTH; i++) begin
            if (mode == MODE_LEADING) begin
                bitv = slice[SLICE_WIDTH-1-i];
            end else begin
                bitv = slice[i];
            end
            if (bitv) begin
                hit = 1'b1;
            end else if (!hit) begin
                count = count + SCW'(1);
            end
        end
    end

    assign all_zero = ~|slice;

endmodule

// File: rtl/wide_zero_counter.sv
// Handshaked zero counter scanning one slice per cycle (trailing or leading).
// Ports: clk, reset (sync, active-high), din/din_mode/din_valid/din_ready in,
// dout/dout_zero/dout_valid/dout_ready out. Optional macro
// WIDE_ZERO_COUNTER_EARLY_EXIT_EN ends the scan after the first slice with a 1.
module wide_zero_counter
    import wide_zero_counter_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SLICE_WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_WIDTH-1:0]              din,
    input  logic                               din_mode,
    input  logic                               din_valid,
    output logic                               din_ready,
    output logic [count_width(DATA_WIDTH)-1:0] dout,
    output logic                               dout_zero,
    output logic                               dout_valid,
    input  logic                               dout_ready
);

    localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
    localparam int CW         = count_width(DATA_WIDTH);
    localparam int SCW        = count_width(SLICE_WIDTH);
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    if (DATA_WIDTH % SLICE_WIDTH != 0) begin : g_width_check
        $fatal(1, "DATA_WIDTH must be a multiple of SLICE_WIDTH");
    end

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   word;
    logic                    mode_q;
    logic [CW-1:0]           count;
    logic [IDX_W-1:0]        idx;
    logic                    found;

    logic [IDX_W-1:0]        sel;
    int                      base;
    logic [SLICE_WIDTH-1:0]  cur_slice;
    logic [SCW-1:0]          sc_count;
    logic                    sc_zero;
    logic                    last;

    // Leading mode walks slices from the top down.
    assign sel = (mode_q == MODE_LEADING)
               ? IDX_W'(NUM_SLICES - 1) - idx
               : idx;
    assign base      = int'(sel) * SLICE_WIDTH;
    assign cur_slice = word[base +: SLICE_WIDTH];
    assign last      = (idx == IDX_W'(NUM_SLICES - 1));

    slice_zero_count #(
        .SLICE_WIDTH (SLICE_WIDTH)
    ) u_slice (
        .slice    (cur_slice),
        .mode     (mode_q),
        .count    (sc_count),
        .all_zero (sc_zero)
    );

    always_comb begin
        state_next = state;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        unique case (state)
            IDLE: begin
                din_ready = 1'b1;
                if (din_valid) state_next = SCAN;
            end
            SCAN: begin
`ifdef WIDE_ZERO_COUNTER_EARLY_EXIT_EN
                if (last || (!found && !sc_zero)) state_next = DONE;
`else
                if (last) state_next = DONE;
`endif
            end
            DONE: begin
                dout_valid = 1'b1;
                if (dout_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            word   <= '0;
            mode_q <= MODE_TRAILING;
            count  <= '0;
            idx    <= '0;
            found  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && din_valid) begin
                word   <= din;
                mode_q <= din_mode;
                count  <= '0;
                idx    <= '0;
                found  <= 1'b0;
            end else if (state == SCAN) begin
                // An all-zero slice reports SLICE_WIDTH, so one add covers both cases.
                if (!found) begin
                    count <= count + CW'(sc_count);
                    if (!sc_zero) found <= 1'b1;
                end
                if (!last) idx <= idx + IDX_W'(1);
            end
        end
    end

    assign dout = count;
    // Only an all-zero word can reach DATA_WIDTH.
    assign dout_zero = (count == CW'(DATA_WIDTH));

endmodule

// File: tb/tb_wide_zero_counter.sv
// Directed self-checking bench for wide_zero_counter (32-bit, 8-bit slices).
// Covers reset, both modes, all-zero, backpressure, back-to-back and mid-scan reset.
module tb_wide_zero_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din;
    logic        din_mode;
    logic        din_valid;
    logic        din_ready;
    logic [5:0]  dout;
    logic        dout_zero;
    logic        dout_valid;
    logic        dout_ready;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    wide_zero_counter #(
        .DATA_WIDTH  (32),
        .SLICE_WIDTH (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_mode   (din_mode),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_zero  (dout_zero),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic m);
        @(negedge clk);
        din       = w;
        din_mode  = m;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = $urandom;
        din_mode  = ~m;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!dout_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop(input string tag);
        @(negedge clk);
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
        chk({tag, "_rdy_after"}, 32'(din_ready), 32'd1);
    endtask

    task automatic xact(input string tag, input logic [31:0] w,
                        input logic m, input int exp_cnt,
                        input logic exp_z, input int exp_lat);
        int lat;
        send(w, m);
        wait_done(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_dout"}, 32'(dout), 32'(exp_cnt));
        chk({tag, "_zero"}, 32'(dout_zero), 32'(exp_z));
        pop(tag);
    endtask

`ifdef WIDE_ZERO_COUNTER_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset      = 1'b1;
        din        = '0;
        din_mode   = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_din_ready", 32'(din_ready), 32'd1);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_dout_zero", 32'(dout_zero), 32'd0);

        xact("tz_100", 32'h0000_0100, 1'b0, 8, 1'b0, EE ? 2 : 4);
        xact("lz_100", 32'h0000_0100, 1'b1, 23, 1'b0, EE ? 3 : 4);
        xact("tz_0", 32'h0, 1'b0, 32, 1'b1, 4);
        xact("lz_0", 32'h0, 1'b1, 32, 1'b1, 4);
        xact("tz_msb", 32'h8000_0000, 1'b0, 31, 1'b0, 4);
        xact("lz_msb", 32'h8000_0000, 1'b1, 0, 1'b0, EE ? 1 : 4);
        xact("lz_mid", 32'h0003_0000, 1'b1, 14, 1'b0, EE ? 2 : 4);

        // Backpressure in DONE while a producer keeps offering a word.
        send(32'h00F0_0000, 1'b0);
        wait_done(lat);
        chk("bp_lat", 32'(lat), EE ? 32'd3 : 32'd4);
        din       = 32'h0000_0001;
        din_mode  = 1'b0;
        din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(dout_valid), 32'd1);
            chk("bp_dout", 32'(dout), 32'd20);
            chk("bp_din_ready", 32'(din_ready), 32'd0);
        end
        @(negedge clk);
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
        chk("b2b_rdy", 32'(din_ready), 32'd1);
        chk("b2b_valid_low", 32'(dout_valid), 32'd0);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = 32'hFFFF_FFFF;
        wait_done(lat);
        chk("b2b_lat", 32'(lat), EE ? 32'd1 : 32'd4);
        chk("b2b_dout", 32'(dout), 32'd0);
        chk("b2b_zero", 32'(dout_zero), 32'd0);
        pop("b2b");

        // Reset during the second scan cycle.
        send(32'h0100_0000, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("mrst_valid", 32'(dout_valid), 32'd0);
        chk("mrst_rdy", 32'(din_ready), 32'd1);
        chk("mrst_dout", 32'(dout), 32'd0);
        xact("post_rst", 32'h0001_0000, 1'b0, 16, 1'b0, EE ? 3 : 4);

        // Reset with a result pending in DONE.
        send(32'h0, 1'b1);
        wait_done(lat);
        chk("drst_pre", 32'(dout_valid), 32'd1);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("drst_valid", 32'(dout_valid), 32'd0);
        chk("drst_dout", 32'(dout), 32'd0);
        chk("drst_zero", 32'(dout_zero), 32'd0);

        // dout_ready while idle must not disturb anything.
        @(negedge clk);
        dout_ready = 1'b1;
        @(negedge clk);
        chk("idle_ready_valid", 32'(dout_valid), 32'd0);
        chk("idle_ready_rdy", 32'(din_ready), 32'd1);
        dout_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/wide_zero_counter.md
Name: wide_zero_counter

Overview:
- Multi-cycle, handshaked zero counter for wide words. Counts trailing zeros (from bit 0 up) or leading zeros (from MSB down), selected per transaction.
- Scans the captured word one SLICE_WIDTH slice per cycle, so wide datapaths meet timing without a flat DATA_WIDTH-deep priority chain.
- Sits between producer and consumer stages with valid/ready on both sides. Next generation of the combinational trailing-zero counter.

Parameters:
- DATA_WIDTH, 32, input word width; must be a multiple of SLICE_WIDTH (elaboration-time check, fatal on violation).
- SLICE_WIDTH, 8, bits examined per scan cycle; NUM_SLICES = DATA_WIDTH/SLICE_WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  DATA_WIDTH  word to scan.
- din_mode  input  1  0 = trailing zeros, 1 = leading zeros.
- din_valid  input  1  producer has a word.
- din_ready  output  1  block can accept a word.
- dout  output  $clog2(DATA_WIDTH)+1  zero count, range 0..DATA_WIDTH.
- dout_zero  output  1  word was all zeros.
- dout_valid  output  1  result available.
- dout_ready  input  1  consumer takes the result.

Behaviour:
- Reset: state IDLE, din_ready=1, dout_valid=0, dout=0, dout_zero=0. Internal word/count/slice index cleared.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - din_ready=1.
  - On din_valid && din_ready: capture din and din_mode, clear count and slice index, go to SCAN.
- SCAN:
  - din_ready=0. Examines one slice per cycle.
  - Trailing mode starts at slice 0 (LSBs) and moves upward. Leading mode starts at slice NUM_SLICES-1 and moves downward.
  - Slice all zero and no 1 found yet: count += SLICE_WIDTH.
  - First slice containing a 1: count += in-slice trailing or leading count; set found.
  - Once found, count is frozen for the remaining slices.
  - After the last slice, go to DONE.
- DONE:
  - dout_valid=1; dout and dout_zero are held stable until dout_valid && dout_ready.
  - On that handshake, go to IDLE.
  - A new word is accepted no earlier than the cycle after the handshake (no same-cycle turnaround).
- Latency, feature off: accept at edge t; SCAN occupies NUM_SLICES cycles; dout_valid rises in the cycle after edge t+NUM_SLICES. Latency is fixed and data-independent.
- All-zero word: dout = DATA_WIDTH, dout_zero=1, in either mode.
- Count arithmetic: count is $clog2(DATA_WIDTH)+1 bits and never overflows, since the maximum is DATA_WIDTH.
- din and din_mode changes while not in IDLE are ignored; only the captured copy is used.
- Reset asserted in any state, including mid-SCAN or DONE with a pending result: the in-flight transaction is discarded. Next cycle is IDLE, with reset values.
- dout_ready asserted while dout_valid=0: no effect.

Optional Feature:
- Macro: WIDE_ZERO_COUNTER_EARLY_EXIT_EN.
- Defined: SCAN goes to DONE on the cycle after the first slice containing a 1 is processed.
  - Latency becomes (index of that slice in scan order + 1) scan cycles.
  - An all-zero word still takes NUM_SLICES cycles.
  - Results are identical to the non-early-exit build.
- Undefined: fixed NUM_SLICES scan cycles, as in Behaviour.

Decomposition:
- Package wide_zero_counter_pkg holds:
  - state enum type (IDLE, SCAN, DONE);
  - mode constants MODE_TRAILING=1'b0 and MODE_LEADING=1'b1;
  - count-width helper function ($clog2(w)+1).
- Sub-module slice_zero_count:
  - combinational, SLICE_WIDTH-bit input, mode input;
  - outputs in-slice count (0..SLICE_WIDTH) and an all-zero flag;
  - instantiated once in the parent.

Test Plan (DATA_WIDTH=32, SLICE_WIDTH=8, NUM_SLICES=4 unless noted):
- Trailing, din=32'h0000_0100 -> dout=8, dout_zero=0; dout_valid exactly 4 scan cycles after accept (feature off).
- Leading, din=32'h0000_0100 -> dout=23, dout_zero=0.
- din=32'h0 in both modes -> dout=32, dout_zero=1; latency 4 scan cycles with the feature on or off.
- din=32'h8000_0000 -> trailing dout=31, leading dout=0. With WIDE_ZERO_COUNTER_EARLY_EXIT_EN, leading finishes after 1 scan cycle and trailing after 4.
- Backpressure: hold dout_ready=0 for 5 cycles in DONE -> dout and dout_valid stable, din_ready=0. Raise dout_ready -> handshake; din_ready=1 next cycle; a back-to-back second word (trailing, 32'h0000_0001) gives dout=0.
- Reset mid-SCAN (second scan cycle) -> next cycle dout_valid=0, din_ready=1, dout=0. A following trailing word 32'h0001_0000 gives dout=16 with no corruption.
